control_fb_pixel_packer: RTL and testbench
==========================================

Name: control_fb_pixel_packer

Overview:
Downstream stage of the frame-read command block. Consumes its byte-wide framebuffer write stream: address (row/col/pixel byte index), data byte, write-enable level and toggle-style access strobe. Assembles BYTES_PER_PIXEL bytes into one pixel word and queues it in a 2-entry FIFO. Presents each word on a valid/ready write port to the framebuffer RAM arbiter.

Parameters:
BYTES_PER_PIXEL, params::BYTES_PER_PIXEL, bytes per pixel word; pixel index counts down BYTES_PER_PIXEL-1..0.
FIFO_DEPTH, 2, output queue depth; only 2 is supported.

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
addr  input  types::fb_addr_t  upstream byte address (row, col, pixel)
data_in  input  8  upstream data byte
ram_write_enable  input  1  upstream write-session level
ram_access_start  input  1  upstream toggle strobe; each change = one byte
wr_row  output  types::row_addr_t  pixel row
wr_col  output  types::col_addr_t  pixel column
wr_data  output  8*BYTES_PER_PIXEL  pixel word; lane k = bits [8k+7:8k]
wr_valid  output  1  FIFO head valid
wr_ready  input  1  RAM side accepts head
busy  output  1  assembling or FIFO non-empty
overflow  output  1  sticky: pixel dropped on full FIFO
partial  output  1  sticky: pixel emitted with missing lanes

Behaviour:
- Reset: wr_row/wr_col/wr_data 0, wr_valid 0, busy 0, overflow 0, partial 0, FIFO empty, lane accumulator and lane mask cleared, prev_start 0, FSM IDLE.
- Strobe detect: prev_start registers ram_access_start every cycle. Byte event = (ram_access_start != prev_start) && ram_write_enable. A toggle with ram_write_enable low is ignored; prev_start still updates.
- On byte event: data_in is written into lane addr.pixel and that lane's mask bit is set. Lane index >= BYTES_PER_PIXEL is ignored and sets partial.
- FSM IDLE: first byte event goes to ASSEMBLE. If that byte already has pixel==0, the pixel completes in the same cycle and the FSM stays IDLE.
- FSM ASSEMBLE: a byte event with addr.pixel==0 completes the pixel:
  - word = accumulated lanes merged with the current byte in lane 0;
  - row/col come from the lane-0 byte's address;
  - the word is pushed to the FIFO;
  - if the mask is not all-ones, missing lanes are 0 and partial is set;
  - mask is cleared and the FSM returns to IDLE.
- Falling ram_write_enable in ASSEMBLE: discard the accumulator, clear the mask, set partial, return to IDLE. Nothing is emitted.
- Latency: the completing byte event is sampled at edge E. If the FIFO was empty, wr_valid=1 with that word after E, so it is visible in cycle E+1.
- FIFO:
  - Pop when wr_valid && wr_ready.
  - Push while full with a simultaneous pop: legal, no loss.
  - Push while full without a pop: word dropped, overflow set, FIFO contents unchanged.
  - FIFO order preserved. wr_row/wr_col/wr_data hold stable while wr_valid && !wr_ready.
- busy = (FSM==ASSEMBLE) || FIFO non-empty; registered.
- Sticky flags clear only on reset.
- Reset mid-pixel or mid-FIFO: everything is discarded; no write is issued after reset deasserts.
- Back-to-back byte events on consecutive cycles are fully supported; throughput is 1 byte/cycle.

Optional Feature:
Macro FB_PIXEL_PACKER_STATS_EN.
- Defined: adds output pixel_count (32-bit). It increments on each FIFO pop, wraps at 2^32-1 -> 0 and resets to 0. It also adds output drop_count (16-bit), which increments on each overflow drop and saturates at 16'hFFFF.
- Undefined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- BYTES_PER_PIXEL=2, wr_ready=1; toggle with addr row0/col0/pixel1 data 8'hAB, then pixel0 data 8'hCD -> one cycle after the second event: wr_valid=1, wr_data=16'hABCD, row0/col0; partial=0.
- wr_ready=0; three complete pixels sent (words 16'h1111, 16'h2222, 16'h3333) -> FIFO holds 1111 and 2222; overflow=1. Raising wr_ready then pops 1111, then 2222; wr_valid=0 afterwards.
- FIFO full, and a pixel completes in the same cycle wr_ready=1 pops the head -> no drop; overflow stays 0; order preserved.
- Only a pixel0 byte 8'h55 sent at col 3 -> wr_data=16'h0055, col 3, partial=1.
- Send pixel1 byte, then drop ram_write_enable before pixel0 -> no write is emitted; partial=1; busy returns to 0. Toggle with enable low -> no effect.
- Reset asserted between the two bytes of a pixel, then pixel0 byte sent after reset -> emitted word 16'h00xx with partial=1; no stale lane data. With FB_PIXEL_PACKER_STATS_EN, pixel_count=1.

Source files
------------

// File: rtl/control_fb_pixel_packer_if.sv
// control_fb_pixel_packer_if: upstream byte stream, pixel write port and status of the packer
interface control_fb_pixel_packer_if #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int PIX_W = 2
);
    logic [ROW_W+COL_W+PIX_W-1:0] addr;
    logic [7:0] data_in;
    logic ram_write_enable;
    logic ram_access_start;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic [8*BYTES_PER_PIXEL-1:0] wr_data;
    logic wr_valid;
    logic wr_ready;
    logic busy;
    logic overflow;
    logic partial;
    modport master (
        output addr, data_in, ram_write_enable, ram_access_start, wr_ready,
        input  wr_row, wr_col, wr_data, wr_valid, busy, overflow, partial
    );
    modport slave (
        input  addr, data_in, ram_write_enable, ram_access_start, wr_ready,
        output wr_row, wr_col, wr_data, wr_valid, busy, overflow, partial
    );
endinterface

// File: rtl/control_fb_pixel_packer.sv
// control_fb_pixel_packer: packs toggle-strobed bytes into pixel words behind a 2-entry FIFO (optional counters: FB_PIXEL_PACKER_STATS_EN)
module control_fb_pixel_packer #(
    parameter int BYTES_PER_PIXEL = 2,
    parameter int FIFO_DEPTH = 2,
    parameter int ROW_W = 8,
    parameter int COL_W = 8,
    parameter int PIX_W = 2
) (
    input logic clk,
    input logic reset,
    control_fb_pixel_packer_if.slave bus
`ifdef FB_PIXEL_PACKER_STATS_EN
    ,
    output logic [31:0] pixel_count_o,
    output logic [15:0] drop_count_o
`endif
);
    localparam int W = 8 * BYTES_PER_PIXEL;
    localparam int EW = ROW_W + COL_W + W;
    typedef enum logic {IDLE, ASSEMBLE} state_t;
    state_t state_q, state_d;
    logic prev_start_q;
    logic [W-1:0] acc_q, acc_d, acc_w;
    logic [BYTES_PER_PIXEL-1:0] mask_q, mask_d, mask_w;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PIX_W-1:0] pix;
    int lane;
    logic ev, in_range, complete, abort, push, pop, drop, partial_set;
    logic [EW-1:0] mem_q [2];
    logic rd_ptr_q, wr_ptr_q;
    logic [1:0] count_q, count_d;
    logic busy_q, overflow_q, partial_q;

    assign {row, col, pix} = bus.addr;
    assign lane = int'(pix);
    assign ev = (bus.ram_access_start != prev_start_q) && bus.ram_write_enable;
    assign in_range = lane < BYTES_PER_PIXEL;
    assign complete = ev && pix == '0;
    assign abort = state_q == ASSEMBLE && !bus.ram_write_enable;
    assign pop = bus.wr_valid && bus.wr_ready;
    // a full FIFO still takes the new word when the head leaves in the same cycle
    assign push = complete && (count_q != 2'(FIFO_DEPTH) || pop);
    assign drop = complete && !push;
    assign partial_set = (ev && !in_range) || abort || (complete && mask_w != '1);
    assign count_d = count_q + 2'(push) - 2'(pop);

    // accumulator as it stands with the current byte merged in
    always_comb begin
        acc_w = acc_q;
        mask_w = mask_q;
        if (ev && in_range) begin
            acc_w[8*lane +: 8] = bus.data_in;
            mask_w[lane] = 1'b1;
        end
    end

    // assembly FSM: a lane-0 byte completes the pixel, a dropped enable discards it
    always_comb begin
        state_d = state_q;
        acc_d = acc_w;
        mask_d = mask_w;
        if (complete || abort) begin
            state_d = IDLE;
            acc_d = '0;
            mask_d = '0;
        end else if (ev) begin
            state_d = ASSEMBLE;
        end
    end

    // state, accumulator, FIFO and sticky status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            prev_start_q <= 1'b0;
            acc_q <= '0;
            mask_q <= '0;
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q <= '0;
            busy_q <= 1'b0;
            overflow_q <= 1'b0;
            partial_q <= 1'b0;
        end else begin
            state_q <= state_d;
            prev_start_q <= bus.ram_access_start;
            acc_q <= acc_d;
            mask_q <= mask_d;
            if (push) begin
                mem_q[wr_ptr_q] <= {row, col, acc_w};
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_d;
            busy_q <= state_d == ASSEMBLE || count_d != '0;
            overflow_q <= overflow_q | drop;
            partial_q <= partial_q | partial_set;
        end
    end

    assign {bus.wr_row, bus.wr_col, bus.wr_data} = mem_q[rd_ptr_q];
    assign bus.wr_valid = count_q != '0;
    assign bus.busy = busy_q;
    assign bus.overflow = overflow_q;
    assign bus.partial = partial_q;

`ifdef FB_PIXEL_PACKER_STATS_EN
    logic [31:0] pixel_count_q;
    logic [15:0] drop_count_q;

    // popped-word counter wraps, drop counter saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            if (pop) pixel_count_q <= pixel_count_q + 32'd1;
            if (drop && drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign pixel_count_o = pixel_count_q;
    assign drop_count_o = drop_count_q;
`endif
endmodule

// File: tb/tb_control_fb_pixel_packer.sv
// tb_control_fb_pixel_packer: directed scoreboard bench for control_fb_pixel_packer (BYTES_PER_PIXEL=2)
module tb_control_fb_pixel_packer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    // free-running clock
    always #5 clk = ~clk;

    control_fb_pixel_packer_if #(.BYTES_PER_PIXEL(2)) bus ();
`ifdef FB_PIXEL_PACKER_STATS_EN
    logic [31:0] pixel_count;
    logic [15:0] drop_count;
`endif

    control_fb_pixel_packer #(.BYTES_PER_PIXEL(2), .FIFO_DEPTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
`ifdef FB_PIXEL_PACKER_STATS_EN
        ,
        .pixel_count_o(pixel_count),
        .drop_count_o(drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [31:0] e;
        if (bus.wr_valid && bus.wr_ready) begin
            chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_word", {bus.wr_row, bus.wr_col, bus.wr_data}, e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] row, input logic [7:0] col, input logic [1:0] pix, input logic [7:0] d);
        bus.addr = {row, col, pix};
        bus.data_in = d;
        bus.ram_write_enable = 1'b1;
        bus.ram_access_start = ~bus.ram_access_start;
        step();
    endtask

    task automatic pixel(input logic [7:0] row, input logic [7:0] col, input logic [15:0] w);
        send(row, col, 2'd1, w[15:8]);
        send(row, col, 2'd0, w[7:0]);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.ram_write_enable = 1'b0;
        bus.wr_ready = 1'b0;
        exp_q.delete();
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        bus.addr = '0;
        bus.data_in = '0;
        bus.ram_write_enable = 1'b0;
        bus.ram_access_start = 1'b0;
        bus.wr_ready = 1'b0;
        @(negedge clk);
        do_reset();
        chk("rst_valid", 32'(bus.wr_valid), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        chk("rst_partial", 32'(bus.partial), 32'd0);
        chk("rst_data", 32'(bus.wr_data), 32'd0);
        chk("rst_rowcol", {16'd0, bus.wr_row, bus.wr_col}, 32'd0);
        bus.wr_ready = 1'b1;
        send(8'd0, 8'd0, 2'd1, 8'hAB);
        chk("asm_busy", 32'(bus.busy), 32'd1);
        exp_q.push_back({8'd0, 8'd0, 16'hABCD});
        send(8'd0, 8'd0, 2'd0, 8'hCD);
        chk("lat_valid", 32'(bus.wr_valid), 32'd1);
        chk("lat_data", 32'(bus.wr_data), 32'h0000ABCD);
        chk("full_partial", 32'(bus.partial), 32'd0);
        step();
        chk("pop_valid", 32'(bus.wr_valid), 32'd0);
        chk("pop_busy", 32'(bus.busy), 32'd0);
        bus.wr_ready = 1'b0;
        exp_q.push_back({8'd1, 8'd1, 16'h1111});
        pixel(8'd1, 8'd1, 16'h1111);
        exp_q.push_back({8'd1, 8'd2, 16'h2222});
        pixel(8'd1, 8'd2, 16'h2222);
        pixel(8'd1, 8'd3, 16'h3333);
        chk("ovf_set", 32'(bus.overflow), 32'd1);
        chk("ovf_head", 32'(bus.wr_data), 32'h00001111);
        chk("ovf_valid", 32'(bus.wr_valid), 32'd1);
`ifdef FB_PIXEL_PACKER_STATS_EN
        chk("drop_count", 32'(drop_count), 32'd1);
`endif
        bus.wr_ready = 1'b1;
        step();
        step();
        chk("ovf_drained", 32'(bus.wr_valid), 32'd0);
        do_reset();
        exp_q.push_back({8'd1, 8'd4, 16'h4444});
        pixel(8'd1, 8'd4, 16'h4444);
        exp_q.push_back({8'd1, 8'd5, 16'h5555});
        pixel(8'd1, 8'd5, 16'h5555);
        send(8'd1, 8'd6, 2'd1, 8'h66);
        bus.wr_ready = 1'b1;
        exp_q.push_back({8'd1, 8'd6, 16'h6666});
        send(8'd1, 8'd6, 2'd0, 8'h66);
        chk("sim_head", 32'(bus.wr_data), 32'h00005555);
        step();
        step();
        chk("sim_overflow", 32'(bus.overflow), 32'd0);
        chk("sim_drained", 32'(bus.wr_valid), 32'd0);
        chk("sim_sb_empty", 32'(exp_q.size()), 32'd0);
        chk("pre_partial", 32'(bus.partial), 32'd0);
        exp_q.push_back({8'd2, 8'd3, 16'h0055});
        send(8'd2, 8'd3, 2'd0, 8'h55);
        chk("part_flag", 32'(bus.partial), 32'd1);
        chk("part_col", 32'(bus.wr_col), 32'd3);
        chk("part_data", 32'(bus.wr_data), 32'h00000055);
        step();
        do_reset();
        bus.wr_ready = 1'b1;
        send(8'd0, 8'd7, 2'd1, 8'h12);
        bus.ram_write_enable = 1'b0;
        step();
        chk("abort_partial", 32'(bus.partial), 32'd1);
        step();
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_valid", 32'(bus.wr_valid), 32'd0);
        bus.ram_access_start = ~bus.ram_access_start;
        step();
        step();
        chk("wel_busy", 32'(bus.busy), 32'd0);
        chk("wel_valid", 32'(bus.wr_valid), 32'd0);
        do_reset();
        bus.wr_ready = 1'b1;
        send(8'd3, 8'd4, 2'd1, 8'h77);
        reset = 1'b1;
        bus.ram_write_enable = 1'b0;
        step();
        reset = 1'b0;
        step();
        chk("mid_rst_partial", 32'(bus.partial), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        exp_q.push_back({8'd3, 8'd4, 16'h009A});
        send(8'd3, 8'd4, 2'd0, 8'h9A);
        chk("mid_rst_flag", 32'(bus.partial), 32'd1);
        chk("mid_rst_data", 32'(bus.wr_data), 32'h0000009A);
        step();
`ifdef FB_PIXEL_PACKER_STATS_EN
        chk("pixel_count", pixel_count, 32'd1);
`endif
        chk("end_sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
